move_sequencer: RTL and testbench

- Sequences the 16-entry register bank in the mcp_23 datapath.
- Fetches 8-bit move instructions {from_addr, to_addr} from instruction memory and drives from_addr, to_addr and enable into reg_bank.
- Enforces the imaginary-register access rules: a (input) and d (alu_ans) are read-only; b (alu_x) and c (alu_y) are write-only.
- Stalls until external input data is valid, and until the ALU result has settled after an operand write.

---
 rtl/move_seq_pkg.sv | 25 ++
 rtl/move_seq_decode.sv | 31 +++
 rtl/move_sequencer.sv | 134 +++++++++++++
 tb/tb_move_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/move_seq_pkg.sv
// Shared types and constants for the mcp_23 move sequencer.
// MOVE_SEQ_STEP_EN adds the STEP state used for single-stepping.
package move_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    WAIT_IN,
    WAIT_ALU,
    EXEC,
    HALT
`ifdef MOVE_SEQ_STEP_EN
    , STEP
`endif
  } state_t;

  localparam logic [3:0] REG_IN      = 4'ha;
  localparam logic [3:0] REG_ALU_X   = 4'hb;
  localparam logic [3:0] REG_ALU_Y   = 4'hc;
  localparam logic [3:0] REG_ALU_ANS = 4'hd;

  localparam logic [7:0] HALT_WORD = 8'hFF;

endpackage

// File: rtl/move_seq_decode.sv
// Combinational classifier for a captured {from, to} move word.
module move_seq_decode
  import move_seq_pkg::*;
#(
  parameter int ADDR_LEN = 4
) (
  input  logic [2*ADDR_LEN-1:0] word,
  output logic                  is_halt,
  output logic                  is_illegal,
  output logic                  needs_in,
  output logic                  needs_alu,
  output logic                  writes_alu
);

  localparam int IW = 2 * ADDR_LEN;

  logic [ADDR_LEN-1:0] from;
  logic [ADDR_LEN-1:0] to;

  assign from = word[IW-1:ADDR_LEN];
  assign to   = word[ADDR_LEN-1:0];

  // a and d are read-only, b and c are write-only
  assign is_halt    = (word == IW'(HALT_WORD));
  assign is_illegal = (from == ADDR_LEN'(REG_ALU_X)) || (from == ADDR_LEN'(REG_ALU_Y)) ||
                      (to == ADDR_LEN'(REG_IN)) || (to == ADDR_LEN'(REG_ALU_ANS));
  assign needs_in   = (from == ADDR_LEN'(REG_IN));
  assign needs_alu  = (from == ADDR_LEN'(REG_ALU_ANS));
  assign writes_alu = (to == ADDR_LEN'(REG_ALU_X)) || (to == ADDR_LEN'(REG_ALU_Y));

endmodule

// File: rtl/move_sequencer.sv
// Fetches move words and drives reg_bank, stalling on input data and ALU settling.
// Optional single-step mode is enabled by defining MOVE_SEQ_STEP_EN.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter int ADDR_LEN = 4,
  parameter int PC_LEN   = 8,
  parameter int ALU_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef MOVE_SEQ_STEP_EN
  input  logic                  step,
`endif
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic [PC_LEN-1:0]     instr_addr,
  output logic                  instr_rd,
  input  logic [2*ADDR_LEN-1:0] instr_data,
  input  logic                  instr_valid,
  input  logic                  in_valid,
  output logic                  in_ack,
  output logic [ADDR_LEN-1:0]   from_addr,
  output logic [ADDR_LEN-1:0]   to_addr,
  output logic                  enable
);

  localparam int IW    = 2 * ADDR_LEN;
  localparam int CNT_W = 4;

  state_t              state, state_d;
  logic [PC_LEN-1:0]   pc, pc_d;
  logic [IW-1:0]       instr, instr_d;
  logic [CNT_W-1:0]    alu_cnt, alu_cnt_d;
  logic                err_d;
  logic                is_halt, is_illegal, needs_in, needs_alu, writes_alu;

  move_seq_decode #(.ADDR_LEN(ADDR_LEN)) u_decode (
    .word       (instr),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .needs_in   (needs_in),
    .needs_alu  (needs_alu),
    .writes_alu (writes_alu)
  );

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    instr_d   = instr;
    err_d     = err;
    alu_cnt_d = (alu_cnt != '0) ? alu_cnt - 1'b1 : alu_cnt;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (instr_valid) begin
          instr_d = instr_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_halt) begin
          state_d = HALT;
        end else if (is_illegal) begin
          err_d   = 1'b1;
          pc_d    = pc + 1'b1;
          state_d = FETCH;
        end else if (needs_in && !in_valid) begin
          state_d = WAIT_IN;
        end else if (needs_alu && (alu_cnt != '0)) begin
          state_d = WAIT_ALU;
        end else begin
          state_d = EXEC;
        end
      end
      WAIT_IN: begin
        if (in_valid) state_d = EXEC;
      end
      WAIT_ALU: begin
        if (alu_cnt == '0) state_d = EXEC;
      end
      EXEC: begin
        pc_d = pc + 1'b1;
        // A fresh operand write restarts the settle window
        if (writes_alu) alu_cnt_d = CNT_W'(ALU_LAT);
`ifdef MOVE_SEQ_STEP_EN
        state_d = STEP;
`else
        state_d = FETCH;
`endif
      end
`ifdef MOVE_SEQ_STEP_EN
      STEP: begin
        if (step) state_d = FETCH;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      instr   <= '0;
      alu_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      instr   <= instr_d;
      alu_cnt <= alu_cnt_d;
      err     <= err_d;
    end
  end

  assign instr_addr = pc;
  assign instr_rd   = (state == FETCH);
  assign enable     = (state == EXEC);
  assign in_ack     = enable && needs_in;
  assign busy       = (state != IDLE) && (state != HALT);
  assign halted     = (state == HALT);
  assign from_addr  = instr[IW-1:ADDR_LEN];
  assign to_addr    = instr[ADDR_LEN-1:0];

endmodule

// File: tb/tb_move_sequencer.sv
// Directed scoreboard bench for move_sequencer (4-word program memory, PC_LEN=2).
module tb_move_sequencer;
  localparam int ADDR_LEN = 4;
  localparam int PC_LEN   = 2;
  localparam int ALU_LAT  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  busy, halted, err, instr_rd, in_ack, enable;
  logic [PC_LEN-1:0]     instr_addr;
  logic [2*ADDR_LEN-1:0] instr_data;
  logic                  instr_valid = 1'b1;
  logic                  in_valid = 1'b1;
  logic [ADDR_LEN-1:0]   from_addr, to_addr;
  logic [7:0]            imem [4];
`ifdef MOVE_SEQ_STEP_EN
  logic                  step;
  assign step = 1'b1;
`endif

  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [8:0]  exp_q [$];
  int          en_cyc [$];
  int          fetch_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign instr_data = imem[instr_addr];

  move_sequencer #(.ADDR_LEN(ADDR_LEN), .PC_LEN(PC_LEN), .ALU_LAT(ALU_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef MOVE_SEQ_STEP_EN
    .step        (step),
`endif
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .instr_addr  (instr_addr),
    .instr_rd    (instr_rd),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .in_valid    (in_valid),
    .in_ack      (in_ack),
    .from_addr   (from_addr),
    .to_addr     (to_addr),
    .enable      (enable)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every enable must match the oldest pushed move
  always @(negedge clk) begin
    if (in_ack && !enable) chk("ack_without_enable", {31'd0, in_ack}, 32'd0);
    if (enable) begin
      en_cyc.push_back(cyc);
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("move", {23'd0, from_addr, to_addr, in_ack}, {23'd0, exp_q.pop_front()});
    end
    if (instr_rd && instr_valid) fetch_q.push_back(int'(instr_addr));
  end

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_halted(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_rd"}, {31'd0, instr_rd}, 32'd0);
    chk({tag, "_en"}, {31'd0, enable}, 32'd0);
    chk({tag, "_ack"}, {31'd0, in_ack}, 32'd0);
    chk({tag, "_addr"}, {30'd0, instr_addr}, 32'd0);
    chk({tag, "_from_to"}, {24'd0, from_addr, to_addr}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, base, nen;

    // Reset state
    imem[0] = 8'h12; imem[1] = 8'hFF; imem[2] = 8'hFF; imem[3] = 8'hFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");

    // Single move then halt
    exp_q.push_back({4'h1, 4'h2, 1'b0});
    base = en_cyc.size();
    pulse_start(s);
    wait_halted(20);
    chk("t1_en_count", en_cyc.size() - base, 1);
    if (en_cyc.size() > base) chk("t1_en_latency", en_cyc[base] - s, 2);
    chk("t1_halt_pc", {30'd0, instr_addr}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_drain", exp_q.size(), 0);

    // ALU settle before d-read
    imem[0] = 8'h0B; imem[1] = 8'h1C; imem[2] = 8'hD3; imem[3] = 8'hFF;
    exp_q.push_back({4'h0, 4'hB, 1'b0});
    exp_q.push_back({4'h1, 4'hC, 1'b0});
    exp_q.push_back({4'hD, 4'h3, 1'b0});
    base = en_cyc.size();
    pulse_start(s);
    wait_halted(40);
    chk("t2_en_count", en_cyc.size() - base, 3);
    if (en_cyc.size() >= base + 3) begin
      chk("t2_gap_write", en_cyc[base+1] - en_cyc[base], 3);
      chk("t2_gap_dread", en_cyc[base+2] - en_cyc[base+1], 4);
    end
    chk("t2_drain", exp_q.size(), 0);

    // Input stall
    imem[0] = 8'hA5; imem[1] = 8'hFF;
    in_valid = 1'b0;
    exp_q.push_back({4'hA, 4'h5, 1'b1});
    base = en_cyc.size();
    pulse_start(s);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t3_stall_busy", {31'd0, busy}, 32'd1);
    chk("t3_stall_no_en", en_cyc.size() - base, 0);
    @(posedge clk);
    #1 in_valid = 1'b1;
    e = cyc;
    wait_halted(20);
    chk("t3_en_count", en_cyc.size() - base, 1);
    if (en_cyc.size() > base) chk("t3_en_after_valid", en_cyc[base] - e, 1);
    chk("t3_drain", exp_q.size(), 0);

    // Illegal moves set sticky err
    imem[0] = 8'hB1; imem[1] = 8'h4A; imem[2] = 8'h12; imem[3] = 8'hFF;
    exp_q.push_back({4'h1, 4'h2, 1'b0});
    base = en_cyc.size();
    pulse_start(s);
    repeat (3) @(negedge clk);
    #1;
    chk("t4_err_set", {31'd0, err}, 32'd1);
    chk("t4_no_en_illegal", en_cyc.size() - base, 0);
    wait_halted(40);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    chk("t4_en_count", en_cyc.size() - base, 1);
    exp_q.push_back({4'h1, 4'h2, 1'b0});
    pulse_start(s);
    @(negedge clk);
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    wait_halted(40);
    chk("t4_drain", exp_q.size(), 0);

    // Reset during WAIT_IN
    imem[0] = 8'hA5; imem[1] = 8'hFF;
    in_valid = 1'b0;
    base = en_cyc.size();
    pulse_start(s);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    chk("t5_no_en", en_cyc.size() - base, 0);
    in_valid = 1'b1;
    exp_q.push_back({4'hA, 4'h5, 1'b1});
    pulse_start(s);
    @(negedge clk);
    chk("t5_fetch_rd", {31'd0, instr_rd}, 32'd1);
    chk("t5_fetch_addr", {30'd0, instr_addr}, 32'd0);
    wait_halted(20);
    chk("t5_drain", exp_q.size(), 0);

    // PC wrap with four non-halt moves
    imem[0] = 8'h12; imem[1] = 8'h23; imem[2] = 8'h34; imem[3] = 8'h45;
    exp_q.push_back({4'h1, 4'h2, 1'b0});
    exp_q.push_back({4'h2, 4'h3, 1'b0});
    exp_q.push_back({4'h3, 4'h4, 1'b0});
    exp_q.push_back({4'h4, 4'h5, 1'b0});
    fetch_q.delete();
    pulse_start(s);
    nen = 0;
    while (fetch_q.size() < 5 && nen < 60) begin
      @(negedge clk);
      #1;
      nen++;
    end
    chk("t6_fetches", fetch_q.size(), 5);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++)
      if (i < fetch_q.size()) chk($sformatf("t6_addr%0d", i), fetch_q[i], i % 4);
    chk("t6_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
